// File: rtl/ram_access_pkg.sv
// Shared encodings for the RAM load/store front end: access sizes, FSM states,
// per-size byte-lane enables and the alignment rule.
package ram_access_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WRITE,
        ST_RESP
    } state_t;

    // Byte-lane enables of a right-justified access, indexed by size code.
    localparam logic [3:0][7:0] SIZE_BMASK = {8'hFF, 8'h0F, 8'h03, 8'h01};

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_HALF:   misaligned = off[0];
            SZ_WORD:   misaligned = |off[1:0];
            SZ_DOUBLE: misaligned = |off;
            default:   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_lane_unit.sv
// Lane steering for one doubleword: load extract/extend and store lane merge.
// Purely combinational, zero latency, no flow control.
module ram_lane_unit (
    input  logic [63:0] i_word,
    input  logic [63:0] i_wdata,
    input  logic [2:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [63:0] o_load,
    output logic [63:0] o_merge
);
    import ram_access_pkg::*;

    logic [5:0]  w_shamt;
    logic [63:0] w_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_lane_mask;
    logic        w_sign;

    assign w_shamt = {i_off, 3'b000};

    always_comb begin
        w_mask = '0;
        for (int b = 0; b < 8; b++) begin
            w_mask[b*8 +: 8] = {8{SIZE_BMASK[i_size][b]}};
        end
    end

    assign w_shifted = i_word >> w_shamt;

    always_comb begin
        case (i_size)
            SZ_BYTE: w_sign = i_signed & w_shifted[7];
            SZ_HALF: w_sign = i_signed & w_shifted[15];
            SZ_WORD: w_sign = i_signed & w_shifted[31];
            default: w_sign = 1'b0;
        endcase
    end

    assign o_load = (w_shifted & w_mask) | ({64{w_sign}} & ~w_mask);

    // A full doubleword mask selects all of wdata, so full stores share this path.
    assign w_lane_mask = w_mask << w_shamt;
    assign o_merge     = (i_word & ~w_lane_mask) | ((i_wdata << w_shamt) & w_lane_mask);

endmodule

// File: rtl/ram_access_ctrl.sv
// Sole master of the 2048x64 RAM: byte-addressed loads/stores with RMW for partial stores.
// One request at a time: load RAM_RD_LAT+1, full store 2, partial store RAM_RD_LAT+2, error 1; no response backpressure.
module ram_access_ctrl #(
    parameter int ADDR_W     = 11,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W+2:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_isReading,
    output logic [63:0]       ram_dataIn,
    input  logic [63:0]       ram_dataOut
);
    import ram_access_pkg::*;

    localparam int              CNT_W    = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_RD_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_word;
    logic [2:0]          r_off;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_write;
    logic                r_err;
    logic [63:0]         r_wdata;
    logic [63:0]         r_rdword;

    logic                w_accept;
    logic                w_rd_done;
    logic                w_misal;
    logic [63:0]         w_load;
    logic [63:0]         w_merge;

    assign w_misal = misaligned(req_size, req_addr[2:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_misal)
                        w_state_nxt = ST_RESP;
                    else if (req_write && req_size == SZ_DOUBLE)
                        w_state_nxt = ST_WRITE;
                    else
                        w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = r_write ? ST_WRITE : ST_RESP;
                end
            end
            ST_WRITE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_word   <= '0;
            r_off    <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= '0;
            r_rdword <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_word   <= req_addr[ADDR_W+2:3];
            r_off    <= req_addr[2:0];
            r_size   <= req_size;
            r_signed <= req_signed;
            r_write  <= req_write;
            r_err    <= w_misal;
            r_wdata  <= req_wdata;
        end else if (r_state == ST_RD_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_rd_done)
                r_rdword <= ram_dataOut;
        end
    end

    ram_lane_unit u_lane (
        .i_word   (r_rdword),
        .i_wdata  (r_wdata),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    // The RAM commits on every edge with isReading low, so it is decoded from state alone.
    assign ram_isReading = (r_state != ST_WRITE);
    assign ram_address   = r_word;
    assign ram_dataIn    = w_merge;
    assign req_ready     = (r_state == ST_IDLE);
    assign resp_valid    = (r_state == ST_RESP);
    assign resp_error    = resp_valid & r_err;
    assign resp_rdata    = (resp_valid && !r_write && !r_err) ? w_load : '0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: two instances (read latency 1 and 3), each with a RAM model,
// checked every cycle against a byte-array memory model.
module tb_ram_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n       [2];
    logic        req_valid     [2];
    logic        req_ready     [2];
    logic        req_write     [2];
    logic [13:0] req_addr      [2];
    logic [1:0]  req_size      [2];
    logic        req_signed    [2];
    logic [63:0] req_wdata     [2];
    logic        resp_valid    [2];
    logic [63:0] resp_rdata    [2];
    logic        resp_error    [2];
    logic [10:0] ram_address   [2];
    logic        ram_isReading [2];
    logic [63:0] ram_dataIn    [2];
    logic [63:0] ram_dataOut   [2];

    ram_access_ctrl #(.ADDR_W(11), .RAM_RD_LAT(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
        .req_signed(req_signed[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]), .ram_address(ram_address[0]),
        .ram_isReading(ram_isReading[0]), .ram_dataIn(ram_dataIn[0]), .ram_dataOut(ram_dataOut[0])
    );

    ram_access_ctrl #(.ADDR_W(11), .RAM_RD_LAT(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
        .req_signed(req_signed[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]), .ram_address(ram_address[1]),
        .ram_isReading(ram_isReading[1]), .ram_dataIn(ram_dataIn[1]), .ram_dataOut(ram_dataOut[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] init_word(input int w);
        return 64'hA5A5_0000_0000_0000 | (64'(w) << 32) | 64'(w);
    endfunction

    // RAM model: writes on every edge with isReading low; read data is only valid once
    // the same address has been presented with isReading high for LAT consecutive cycles.
    logic [63:0] mem [2][2048];
    logic        preload;
    int          cyc = 0;
    int          run_q     [2];
    int          run_now   [2];
    logic [10:0] prev_addr [2];
    logic        prev_rd   [2];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            run_now[k] = 0;
            if (ram_isReading[k])
                run_now[k] = (prev_rd[k] && ram_address[k] == prev_addr[k]) ? run_q[k] + 1 : 1;
        end
    end

    assign ram_dataOut[0] = (run_now[0] >= lat_of(0)) ? mem[0][ram_address[0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    assign ram_dataOut[1] = (run_now[1] >= lat_of(1)) ? mem[1][ram_address[1]] : 64'hBAD0_BAD0_BAD0_BAD0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (preload) begin
                for (int w = 0; w < 2048; w++) mem[k][w] <= init_word(w);
            end else if (!ram_isReading[k]) begin
                mem[k][ram_address[k]] <= ram_dataIn[k];
            end
            run_q[k]     <= (run_now[k] > 100000) ? 100000 : run_now[k];
            prev_addr[k] <= ram_address[k];
            prev_rd[k]   <= ram_isReading[k];
        end
    end

    // Expectations published by the stimulus process; all comparisons happen in the monitor.
    logic [7:0]  mb [2][16384];
    int          exp_cyc    [2];
    logic [63:0] exp_r      [2];
    logic        exp_e      [2];
    int          acc_cyc    [2];
    int          busy_until [2];
    int          wr_cyc     [2];
    logic [10:0] wr_addr    [2];
    logic [63:0] wr_data    [2];
    logic        lit_en     [2];
    logic [63:0] lit_r      [2];
    int          lit_l      [2];
    int          mchk_cyc;
    int          mchk_k;
    logic [63:0] mchk_exp   [3];

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [inst %0d] cycle %0d: actual %h required %h", nm, k, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n[k]) begin
                check("rst_req_ready", k, 64'(req_ready[k]), 64'd1);
                check("rst_resp_valid", k, 64'(resp_valid[k]), 64'd0);
                check("rst_resp_error", k, 64'(resp_error[k]), 64'd0);
                check("rst_resp_rdata", k, resp_rdata[k], 64'd0);
                check("rst_isReading", k, 64'(ram_isReading[k]), 64'd1);
                check("rst_address", k, 64'(ram_address[k]), 64'd0);
                check("rst_dataIn", k, ram_dataIn[k], 64'd0);
            end else begin
                check("req_ready", k, 64'(req_ready[k]), 64'(cyc > busy_until[k]));
                check("ram_isReading", k, 64'(ram_isReading[k]), 64'(cyc != wr_cyc[k]));
                if (cyc == wr_cyc[k]) begin
                    check("write_address", k, 64'(ram_address[k]), 64'(wr_addr[k]));
                    check("write_data", k, ram_dataIn[k], wr_data[k]);
                end
                check("resp_valid", k, 64'(resp_valid[k]), 64'(cyc == exp_cyc[k]));
                if (cyc == exp_cyc[k]) begin
                    check("resp_rdata", k, resp_rdata[k], exp_r[k]);
                    check("resp_error", k, 64'(resp_error[k]), 64'(exp_e[k]));
                    if (lit_en[k]) check("lit_rdata", k, resp_rdata[k], lit_r[k]);
                    if (lit_l[k] != 0) check("lit_latency", k, 64'(cyc - acc_cyc[k] + 1), 64'(lit_l[k]));
                end
            end
        end
        if (cyc == mchk_cyc) begin
            for (int i = 0; i < 3; i++) check("ram_word", mchk_k, mem[mchk_k][1023+i], mchk_exp[i]);
        end
    end

    function automatic logic [63:0] model_word(input int k, input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v |= 64'(mb[k][w*8+i]) << (8*i);
        return v;
    endfunction

    task automatic do_req(input int k, input logic wr, input logic [13:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [63:0] wdata,
                          input logic le, input logic [63:0] lr, input int ll);
        int a, nb, lat;
        logic mis;
        logic [63:0] val, msk;
        @(negedge clk);
        lit_en[k] = le; lit_r[k] = lr; lit_l[k] = ll;
        req_write[k] = wr; req_addr[k] = addr; req_size[k] = size;
        req_signed[k] = sgn; req_wdata[k] = wdata; req_valid[k] = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        // Hostile request held while busy: must be ignored.
        req_write[k] = 1'b1; req_addr[k] = '0; req_size[k] = 2'd3; req_wdata[k] = '1;
        nb  = 1 << size;
        mis = (int'(addr) % nb) != 0;
        msk = (nb == 8) ? '1 : ((64'd1 << (8*nb)) - 64'd1);
        val = '0;
        if (mis) begin
            lat = 1;
        end else if (!wr) begin
            lat = lat_of(k) + 1;
            for (int i = 0; i < nb; i++) val |= 64'(mb[k][int'(addr)+i]) << (8*i);
            if (sgn && val[8*nb-1]) val |= ~msk;
        end else begin
            lat = (nb == 8) ? 2 : lat_of(k) + 2;
            for (int i = 0; i < nb; i++) mb[k][int'(addr)+i] = wdata[8*i +: 8];
            wr_addr[k] = addr[13:3];
            wr_data[k] = model_word(k, int'(addr[13:3]));
        end
        wr_cyc[k]     = (wr && !mis) ? a + lat - 2 : -1;
        exp_r[k]      = val;
        exp_e[k]      = mis;
        exp_cyc[k]    = a + lat - 1;
        acc_cyc[k]    = a;
        busy_until[k] = a + lat - 1;
        repeat (lat) @(negedge clk);
        req_valid[k] = 1'b0;
        #1;
    endtask

    task automatic do_abort(input int k, input logic [13:0] addr, input logic [1:0] size,
                            input logic [63:0] wdata, input int skip);
        int a;
        @(negedge clk);
        req_write[k] = 1'b1; req_addr[k] = addr; req_size[k] = size;
        req_signed[k] = 1'b0; req_wdata[k] = wdata; req_valid[k] = 1'b1;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        a = cyc;
        exp_cyc[k] = -1; wr_cyc[k] = -1; busy_until[k] = a + skip - 1;
        repeat (skip) @(posedge clk);
        #2 reset_n[k] = 1'b0;
        #5 reset_n[k] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic mem_check(input int k, input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
        @(negedge clk); #1;
        mchk_k = k; mchk_exp[0] = e0; mchk_exp[1] = e1; mchk_exp[2] = e2;
        mchk_cyc = cyc + 1;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] iw;
        mchk_cyc = -1; mchk_k = 0;
        for (int i = 0; i < 3; i++) mchk_exp[i] = '0;
        for (int k = 0; k < 2; k++) begin
            reset_n[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
            req_size[k] = '0; req_signed[k] = 1'b0; req_wdata[k] = '0;
            exp_cyc[k] = -1; exp_r[k] = '0; exp_e[k] = 1'b0; acc_cyc[k] = 0; busy_until[k] = -1;
            wr_cyc[k] = -1; wr_addr[k] = '0; wr_data[k] = '0;
            lit_en[k] = 1'b0; lit_r[k] = '0; lit_l[k] = 0;
            for (int a = 0; a < 16384; a++) begin
                iw = init_word(a >> 3);
                mb[k][a] = iw[(a%8)*8 +: 8];
            end
        end
        preload = 1'b1;
        @(posedge clk); #1 preload = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n[0] = 1'b1; reset_n[1] = 1'b1;
        repeat (20) @(negedge clk);
        mem_check(0, init_word(1023), init_word(1024), init_word(1025));

        // RAM_RD_LAT = 1
        do_req(0, 1, 14'h2000, 2'd3, 0, 64'h0000_0000_0000_FF04, 0, 64'd0, 2);
        do_req(0, 0, 14'h2000, 2'd3, 0, 64'd0, 1, 64'h0000_0000_0000_FF04, 2);
        do_req(0, 1, 14'h2003, 2'd0, 0, 64'h0000_0000_0000_00AB, 0, 64'd0, 3);
        mem_check(0, init_word(1023), 64'h0000_0000_AB00_FF04, init_word(1025));
        do_req(0, 0, 14'h2003, 2'd0, 1, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFAB, 2);
        do_req(0, 0, 14'h2003, 2'd0, 0, 64'd0, 1, 64'h0000_0000_0000_00AB, 2);
        do_req(0, 0, 14'h2000, 2'd1, 1, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FF04, 2);
        do_req(0, 0, 14'h2002, 2'd2, 0, 64'd0, 1, 64'd0, 1);
        do_req(0, 1, 14'h2001, 2'd1, 0, 64'h1234, 1, 64'd0, 1);
        do_req(0, 1, 14'h2004, 2'd2, 0, 64'hFFFF_FFFF_DEAD_BEEF, 0, 64'd0, 3);
        do_req(0, 0, 14'h2004, 2'd2, 1, 64'd0, 1, 64'hFFFF_FFFF_DEAD_BEEF, 2);
        do_req(0, 1, 14'h2006, 2'd1, 0, 64'hCCCC_CCCC_CCCC_5A12, 0, 64'd0, 3);
        do_req(0, 0, 14'h2000, 2'd3, 0, 64'd0, 1, 64'h5A12_BEEF_AB00_FF04, 2);
        do_abort(0, 14'h2001, 2'd0, 64'h77, 0);
        mem_check(0, init_word(1023), 64'h5A12_BEEF_AB00_FF04, init_word(1025));
        do_req(0, 0, 14'h2000, 2'd2, 0, 64'd0, 1, 64'h0000_0000_AB00_FF04, 2);

        // RAM_RD_LAT = 3
        do_req(1, 1, 14'h2000, 2'd3, 0, 64'h8000_0000_0000_00C3, 0, 64'd0, 2);
        do_req(1, 0, 14'h2000, 2'd3, 0, 64'd0, 1, 64'h8000_0000_0000_00C3, 4);
        do_req(1, 0, 14'h2007, 2'd0, 1, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FF80, 4);
        do_req(1, 1, 14'h2001, 2'd0, 0, 64'h5A, 0, 64'd0, 5);
        do_req(1, 0, 14'h2000, 2'd1, 0, 64'd0, 1, 64'h0000_0000_0000_5AC3, 4);
        do_req(1, 1, 14'h2003, 2'd2, 0, 64'd0, 1, 64'd0, 1);
        do_abort(1, 14'h2002, 2'd1, 64'hBEEF, 1);
        mem_check(1, init_word(1023), 64'h8000_0000_0000_5AC3, init_word(1025));
        do_req(1, 0, 14'h2000, 2'd3, 0, 64'd0, 1, 64'h8000_0000_0000_5AC3, 4);

        repeat (5) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
